// File: rtl/cu_fsm_mc_pkg.sv
// Shared types for the multicycle OTTER control unit: state encoding, opcodes, trap causes.
// MULDIV state exists only when CU_FSM_MULDIV_EN is defined.
package otter_cu_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WR_BK  = 3'd4,
      INTRPT = 3'd5,
      TRAP   = 3'd6
`ifdef CU_FSM_MULDIV_EN
      , MULDIV = 3'd7
`endif
   } cu_state_t;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [1:0] TRAP_ILLEGAL  = 2'd0;
   localparam logic [1:0] TRAP_FETCH_TO = 2'd1;
   localparam logic [1:0] TRAP_DATA_TO  = 2'd2;

   // Instructions that write the register file and PC in a single EXEC cycle.
   function automatic logic is_alu_op(input logic [6:0] op);
      return (op == OPC_OP) || (op == OPC_OP_IMM) || (op == OPC_JALR) ||
             (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL);
   endfunction

endpackage

// File: rtl/cu_fsm_mc_irq_prio.sv
// Lowest-index-wins priority encoder over the enabled interrupt lines.
module cu_irq_prio #(
   parameter  int W  = 1,
   localparam int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  i_req,
   output logic [IW-1:0] o_idx,
   output logic          o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = |i_req;
      // Scan downward so the lowest set index is the last one written.
      for (int i = W - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IW'(i);
      end
   end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multicycle OTTER control unit: Moore/Mealy FSM with fetch/data timeouts, traps and interrupts.
// Optional iterative mul/div handshake is enabled by defining CU_FSM_MULDIV_EN.
module cu_fsm_mc
   import otter_cu_pkg::*;
#(
   parameter  int IRQ_W    = 1,
   parameter  int MAX_WAIT = 15,
   localparam int IC_W     = (IRQ_W > 1) ? $clog2(IRQ_W) : 1,
   localparam int WC_W     = $clog2(MAX_WAIT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IRQ_W-1:0] irq,
   input  logic             mie,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func3,
   input  logic             funct7_0,
   input  logic             imem_ack,
   input  logic             dmem_ack,
`ifdef CU_FSM_MULDIV_EN
   input  logic             muldiv_done,
   output logic             muldiv_start,
`endif
   output logic             pc_w_en,
   output logic             rfile_w_en,
   output logic             mem_we2,
   output logic             mem_rden1,
   output logic             mem_rden2,
   output logic             cu_rst,
   output logic             csr_we,
   output logic             int_taken,
   output logic             trap_taken,
   output logic [IC_W-1:0]  int_cause,
   output logic [1:0]       trap_cause
);

   cu_state_t        r_state;
   cu_state_t        w_next;
   logic [WC_W-1:0]  r_wait;
   logic [IC_W-1:0]  r_int_cause;
   logic [1:0]       r_trap_cause;
   logic [IRQ_W-1:0] w_irq_masked;
   logic [IC_W-1:0]  w_irq_idx;
   logic             w_irq_vld;
   logic             w_timeout;
   logic             w_done;
   logic             w_trap;
   logic [1:0]       w_trap_cause;
   logic             w_unused;

   assign w_irq_masked = irq & {IRQ_W{mie}};
   assign w_timeout    = (r_wait == WC_W'(MAX_WAIT - 1));
   assign int_cause    = r_int_cause;
   assign trap_cause   = r_trap_cause;
`ifdef CU_FSM_MULDIV_EN
   assign w_unused     = &{1'b0, func3[2:1]};
`else
   assign w_unused     = &{1'b0, func3[2:1], funct7_0};
`endif

   cu_irq_prio #(.W(IRQ_W)) u_irq_prio (
      .i_req (w_irq_masked),
      .o_idx (w_irq_idx),
      .o_vld (w_irq_vld)
   );

   always_comb begin
      pc_w_en      = 1'b0;
      rfile_w_en   = 1'b0;
      mem_we2      = 1'b0;
      mem_rden1    = 1'b0;
      mem_rden2    = 1'b0;
      cu_rst       = 1'b0;
      csr_we       = 1'b0;
      int_taken    = 1'b0;
      trap_taken   = 1'b0;
`ifdef CU_FSM_MULDIV_EN
      muldiv_start = 1'b0;
`endif
      w_next       = r_state;
      w_done       = 1'b0;
      w_trap       = 1'b0;
      w_trap_cause = TRAP_ILLEGAL;
      case (r_state)
         INIT: begin
            cu_rst = 1'b1;
            w_next = FETCH;
         end
         FETCH: begin
            mem_rden1 = 1'b1;
            if (imem_ack) begin
               w_next = EXEC;
            end else if (w_timeout) begin
               w_trap       = 1'b1;
               w_trap_cause = TRAP_FETCH_TO;
            end
         end
         EXEC: begin
`ifdef CU_FSM_MULDIV_EN
            if (opcode == OPC_OP && funct7_0) begin
               muldiv_start = 1'b1;
               w_next       = MULDIV;
            end else
`endif
            if (is_alu_op(opcode)) begin
               rfile_w_en = 1'b1;
               pc_w_en    = 1'b1;
               w_done     = 1'b1;
            end else if (opcode == OPC_BRANCH) begin
               pc_w_en = 1'b1;
               w_done  = 1'b1;
            end else if (opcode == OPC_SYSTEM) begin
               pc_w_en    = 1'b1;
               csr_we     = func3[0];
               rfile_w_en = func3[0];
               w_done     = 1'b1;
            end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
               w_next = MEM;
            end else begin
               w_trap       = 1'b1;
               w_trap_cause = TRAP_ILLEGAL;
            end
         end
         MEM: begin
            // The instruction register holds the opcode for the whole instruction.
            if (opcode == OPC_STORE) begin
               mem_we2 = 1'b1;
               if (dmem_ack) begin
                  pc_w_en = 1'b1;
                  w_done  = 1'b1;
               end
            end else begin
               mem_rden2 = 1'b1;
               if (dmem_ack) w_next = WR_BK;
            end
            if (!dmem_ack && w_timeout) begin
               w_trap       = 1'b1;
               w_trap_cause = TRAP_DATA_TO;
            end
         end
         WR_BK: begin
            rfile_w_en = 1'b1;
            pc_w_en    = 1'b1;
            w_done     = 1'b1;
         end
         INTRPT: begin
            int_taken = 1'b1;
            pc_w_en   = 1'b1;
            w_next    = FETCH;
         end
         TRAP: begin
            trap_taken = 1'b1;
            pc_w_en    = 1'b1;
            w_next     = FETCH;
         end
`ifdef CU_FSM_MULDIV_EN
         MULDIV: begin
            if (muldiv_done) begin
               rfile_w_en = 1'b1;
               pc_w_en    = 1'b1;
               w_done     = 1'b1;
            end
         end
`endif
         default: w_next = INIT;
      endcase
      if (w_done) w_next = w_irq_vld ? INTRPT : FETCH;
      if (w_trap) w_next = TRAP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= INIT;
         r_wait       <= '0;
         r_int_cause  <= '0;
         r_trap_cause <= TRAP_ILLEGAL;
      end else begin
         r_state <= w_next;
         // Counter restarts whenever FETCH or MEM is (re)entered and saturates while waiting.
         if (w_next == r_state && (r_state == FETCH || r_state == MEM)) begin
            if (r_wait != WC_W'(MAX_WAIT)) r_wait <= r_wait + 1'b1;
         end else begin
            r_wait <= '0;
         end
         if (w_done && w_irq_vld) r_int_cause <= w_irq_idx;
         if (w_trap) r_trap_cause <= w_trap_cause;
      end
   end

endmodule

// File: doc/cu_fsm_mc.md
CU_FSM_MC -- requirements
Module: cu_fsm_mc

Interface
REQ-001 SHALL have parameter IRQ_W, default 1, number of interrupt request lines (1..16).
REQ-002 SHALL have parameter MAX_WAIT, default 15, number of cycles without memory ack before a timeout trap (1..255).
REQ-003 SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port irq, input, IRQ_W, level interrupt requests; bit 0 has the highest priority.
REQ-006 SHALL have port mie, input, 1, global interrupt enable.
REQ-007 SHALL have ports opcode (input, 7), func3 (input, 3) and funct7_0 (input, 1, instruction bit 25).
REQ-008 SHALL have ports imem_ack and dmem_ack, input, 1 each, memory completion handshakes.
REQ-009 SHALL have outputs pc_w_en, rfile_w_en, mem_we2, mem_rden1, mem_rden2, cu_rst, csr_we, int_taken and trap_taken, 1 bit each.
REQ-010 SHALL have output int_cause, max(1,clog2(IRQ_W)) bits, giving the index of the interrupt taken.
REQ-011 SHALL have output trap_cause, 2 bits: 0 illegal opcode, 1 fetch timeout, 2 data timeout.
REQ-012 SHALL have input muldiv_done and output muldiv_start, 1 bit each, present only when CU_FSM_MULDIV_EN is defined.

Function
REQ-013 SHALL use states INIT, FETCH, EXEC, MEM, WR_BK, INTRPT, TRAP (and MULDIV when configured); any unused encoding SHALL return to INIT on the next cycle.
REQ-014 SHALL decode outputs combinationally from the registered state and the current inputs; every output not stated as asserted SHALL be 0.
REQ-015 INIT: assert cu_rst for exactly 1 cycle, then go to FETCH.
REQ-016 FETCH: hold mem_rden1 high; on imem_ack go to EXEC; after MAX_WAIT cycles without ack go to TRAP with cause 1.
REQ-017 EXEC, opcodes R/OP-IMM/JALR/LUI/AUIPC/JAL: assert rfile_w_en and pc_w_en for 1 cycle; B-type: pc_w_en only.
REQ-018 EXEC, SYSTEM (0x73): assert pc_w_en; when func3[0]=1, also assert csr_we and rfile_w_en.
REQ-019 EXEC, LOAD/STORE: no outputs asserted; go to MEM.
REQ-020 MEM, load: hold mem_rden2 until dmem_ack, then go to WR_BK.
REQ-021 MEM, store: hold mem_we2 until dmem_ack, and assert pc_w_en in the ack cycle.
REQ-022 MEM timeout after MAX_WAIT cycles without ack: go to TRAP with cause 2; no write enables asserted.
REQ-023 WR_BK: assert rfile_w_en and pc_w_en for 1 cycle.
REQ-024 EXEC with an undefined opcode: assert no write enables; go to TRAP with cause 0.
REQ-025 Instruction-completion cycles (EXEC single-cycle, store ack, WR_BK): if (irq & mie) is nonzero, go to INTRPT, else go to FETCH.
REQ-026 On entering INTRPT, register the lowest set index of (irq & mie) into int_cause; int_cause SHALL hold until the next interrupt is taken.
REQ-027 INTRPT: assert int_taken and pc_w_en for 1 cycle, then go to FETCH.
REQ-028 TRAP: assert trap_taken and pc_w_en for 1 cycle, then go to FETCH; trap_cause SHALL hold until the next trap.
REQ-029 A trap SHALL take priority over a pending interrupt.
REQ-030 An ack in the same cycle as timeout expiry SHALL count as success.
REQ-031 The wait counter SHALL be clog2(MAX_WAIT+1) bits wide, clear on entry to FETCH or MEM, and saturate (never wrap).

Reset
REQ-032 On a clk edge with rst=1: state<=INIT, wait counter<=0, int_cause<=0, trap_cause<=0.
REQ-033 In the cycle after that edge, cu_rst=1 and all other outputs are 0.
REQ-034 rst mid-operation (including during MEM or MULDIV) SHALL abandon the operation with no write enable asserted afterwards.

Configuration
REQ-035 With CU_FSM_MULDIV_EN defined: R-type with funct7_0=1 pulses muldiv_start in EXEC and goes to MULDIV.
REQ-036 MULDIV SHALL wait without timeout until muldiv_done, then assert rfile_w_en and pc_w_en in that cycle and apply REQ-025.
REQ-037 Without CU_FSM_MULDIV_EN: there is no MULDIV state, the muldiv ports are absent, and R-type executes per REQ-017 regardless of funct7_0.

Structure
REQ-038 Package otter_cu_pkg SHALL hold the state enum, opcode constants and trap-cause constants.
REQ-039 Sub-module cu_irq_prio SHALL implement the IRQ_W-wide lowest-index priority encoder with a valid flag.

Verification
REQ-040 ADDI with imem_ack on the 3rd FETCH cycle -> mem_rden1 high for 3 cycles, then rfile_w_en=pc_w_en=1 for exactly 1 cycle.
REQ-041 LW with dmem_ack after 2 cycles -> mem_rden2 high for 2 cycles, then WR_BK cycle with rfile_w_en=1.
REQ-042 MAX_WAIT=4, imem_ack never asserted -> trap_taken=1 with trap_cause=1 after 4 FETCH cycles; ack on cycle 4 -> EXEC, no trap.
REQ-043 IRQ_W=4, irq=4'b1010, mie=1 at SW completion -> INTRPT with int_cause=1; with mie=0 -> FETCH.
REQ-044 Opcode 0x7F with irq pending -> TRAP cause 0 first, then FETCH, then INTRPT after the next instruction.
REQ-045 rst asserted during MEM store -> mem_we2 drops, then cu_rst=1 for 1 cycle; with the macro, MUL with done after 5 cycles -> a single write.
